rr_decoder_arbiter: RTL and testbench
=====================================

Name: rr_decoder_arbiter

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 2-to-4 decoder.
- Drives the decoder's address0, address1 and enable inputs so exactly one decoder output line is asserted for the current owner.
- Holds a grant until the owner releases, drops its request, or a hold timeout expires.
- Inserts a one-cycle enable-low gap between grants, so the gate-delayed decoder never sees an address change while enabled.

Parameters:
- HOLD_MAX, 15: maximum cycles a grant may be held before forced release; legal range 1..(2^CNT_W - 1).
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i.
- release  input  1  the current owner ends its grant.
- address0  output  1  grant index bit 0, to the decoder.
- address1  output  1  grant index bit 1, to the decoder.
- enable  output  1  decoder enable; high only in state GRANT.
- busy  output  1  high in GRANT or GAP.
- timeout  output  1  one-cycle pulse when a grant is forcibly ended by HOLD_MAX.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- All outputs are registered.
- Reset (reset_n low, immediate, regardless of clk):
  - state=IDLE, ptr=0, {address1,address0}=00, enable=0, busy=0, timeout=0, hold counter=0.
  - Reset asserted mid-grant drops enable immediately.
  - After reset_n deasserts, the first arbitration happens at the first clk edge.
- State machine states: IDLE, GRANT, GAP.
- IDLE:
  - If req==0000, stay in IDLE; outputs unchanged; address holds its last value.
  - Otherwise, at the clk edge select the first set req bit scanning ptr, ptr+1, ... mod 4.
  - Load the selected index into {address1,address0}, set enable=1 and busy=1, clear the counter, go to GRANT.
  - Latency: req sampled high at edge N gives enable=1 after edge N.
- GRANT:
  - Increment the counter each cycle; it saturates at HOLD_MAX.
  - Exit to GAP at the next edge if any of these holds:
    - (a) release==1;
    - (b) req[granted]==0;
    - (c) counter==HOLD_MAX-1, i.e. the grant has lasted HOLD_MAX cycles.
  - On exit: enable=0, busy stays 1, ptr=(granted+1) mod 4.
  - timeout=1 for exactly one cycle only when (c) is true and (a) and (b) are both false. Release wins over timeout if both occur in the same cycle.
  - Requests from other requesters arriving during GRANT are ignored until IDLE.
- GAP:
  - Lasts exactly one cycle.
  - enable=0; address held at the previous grant value, so it never changes in the same cycle enable falls.
  - Next state is always IDLE; busy=0 in IDLE.
- Fairness:
  - The requester just served has lowest priority at the next arbitration.
  - With all four requesting continuously, grants rotate 0,1,2,3,0...
- Grant spacing: minimum 3 cycles per grant (GRANT 1, GAP 1, IDLE 1). Back-to-back grants have enable low for exactly 2 cycles.
- release while in IDLE or GAP is ignored.
- Invariants checked in the bench:
  - enable==1 implies req[address] was high at the grant edge.
  - address changes only on the IDLE→GRANT edge.

Test Plan:
- Reset: reset_n=0 for 2 cycles with req=1111 → address=00, enable=0, busy=0. After release of reset, first grant goes to requester 0 (ptr=0).
- Rotation: req=1111 held, release pulsed 1 cycle after each grant → grant sequence 0,1,2,3,0. Enable low exactly 2 cycles between grants; timeout never pulses.
- Skip idle requesters: ptr=1 after serving 0, req=1001 → next grant is 3, then 0.
- Timeout: HOLD_MAX=15, req=0100 held, release never asserted → enable high exactly 15 cycles, timeout pulses once on the GAP entry edge, then requester 2 is re-granted after IDLE.
- Request drop: grant to 1, req[1] falls after 4 cycles → enable falls on the next edge, timeout=0, ptr=2.
- Async reset mid-grant: reset_n low mid-cycle while enable=1 → enable=0 before the next clk edge; state IDLE, ptr=0 after reset is removed.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter driving a 2-to-4 decoder (address1/address0/enable).
// Latency: req at edge N -> enable after edge N; a one-cycle GAP separates grants. No backpressure.
// release_grant: the owner ends its grant ("release" is a reserved word in SystemVerilog).
module rr_decoder_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       release_grant,
    output logic       address0,
    output logic       address1,
    output logic       enable,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state, state_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [1:0]         addr, addr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               en_nxt, busy_nxt, to_nxt;
    logic               pick_vld;
    logic [1:0]         pick_idx;
    logic               exit_rel, exit_drop, exit_hold, grant_end;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr + 2'(k);
            end
        end
    end

    assign exit_rel  = release_grant;
    assign exit_drop = ~req[addr];
    assign exit_hold = (cnt == CNT_W'(HOLD_MAX - 1));
    assign grant_end = (state == GRANT) && (exit_rel || exit_drop || exit_hold);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = GRANT;
            GRANT:   if (grant_end) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs; address only moves on IDLE->GRANT.
    always_comb begin
        addr_nxt = addr;
        ptr_nxt  = ptr;
        cnt_nxt  = cnt;
        en_nxt   = 1'b0;
        busy_nxt = 1'b0;
        to_nxt   = 1'b0;
        case (state)
            GRANT: begin
                en_nxt   = 1'b1;
                busy_nxt = 1'b1;
                if (cnt != CNT_W'(HOLD_MAX)) cnt_nxt = cnt + 1'b1;
                if (grant_end) begin
                    en_nxt  = 1'b0;
                    ptr_nxt = addr + 2'd1;
                    to_nxt  = exit_hold && !exit_rel && !exit_drop;
                end
            end
            GAP: begin
                en_nxt   = 1'b0;
                busy_nxt = 1'b0;
            end
            default: begin
                if (pick_vld) begin
                    addr_nxt = pick_idx;
                    en_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                    cnt_nxt  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr    <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= '0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            addr    <= addr_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            enable  <= en_nxt;
            busy    <= busy_nxt;
            timeout <= to_nxt;
        end
    end

    assign address0 = addr[0];
    assign address1 = addr[1];

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: per-cycle vector table plus hand sequences
// for hold timeout, request drop and asynchronous reset mid-grant.
module tb_rr_decoder_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       release_grant;
    logic       address0, address1, enable, busy, timeout;

    int nvec;
    int nerr;
    logic [1:0] prev_addr;
    logic       prev_en;
    logic       prev_vld;

    rr_decoder_arbiter #(.HOLD_MAX(15), .CNT_W(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .release_grant (release_grant),
        .address0      (address0),
        .address1      (address1),
        .enable        (enable),
        .busy          (busy),
        .timeout       (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rel;
        logic [1:0] a;
        logic       e;
        logic       b;
        logic       t;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic r, logic [3:0] q, logic l, logic [1:0] a, logic e, logic b, logic t);
        vec_t v;
        v.rst_n = r; v.req = q; v.rel = l; v.a = a; v.e = e; v.b = b; v.t = t;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares outputs and checks the address/enable invariants against the previous sample.
    task automatic check(input string name, input logic [1:0] ea, input logic ee, input logic eb, input logic et);
        logic [1:0] a;
        a = {address1, address0};
        nvec++;
        if ({a, enable, busy, timeout} !== {ea, ee, eb, et}) begin
            nerr++;
            $display("FAIL %s: got addr=%0d en=%b busy=%b to=%b, want addr=%0d en=%b busy=%b to=%b",
                     name, a, enable, busy, timeout, ea, ee, eb, et);
        end
        if (reset_n && prev_vld && a != prev_addr) begin
            nvec++;
            if (!(enable && !prev_en)) begin
                nerr++;
                $display("FAIL %s addr_change: addr %0d->%0d with en %b->%b", name, prev_addr, a, prev_en, enable);
            end
        end
        if (reset_n && prev_vld && enable && !prev_en) begin
            nvec++;
            if (!req[a]) begin
                nerr++;
                $display("FAIL %s grant_req: granted %0d but req=%b", name, a, req);
            end
        end
        prev_addr = a;
        prev_en   = enable;
        prev_vld  = reset_n;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        prev_vld = 1'b0;
        prev_addr = 2'd0;
        prev_en = 1'b0;
        reset_n = 1'b0;
        req = 4'b1111;
        release_grant = 1'b0;

        // reset, rotation 0..3,0, skip to 3 then 0, drop, idle release
        tbl[0]  = mk(0, 4'b1111, 0, 2'd0, 0, 0, 0);
        tbl[1]  = mk(0, 4'b1111, 0, 2'd0, 0, 0, 0);
        tbl[2]  = mk(1, 4'b1111, 0, 2'd0, 1, 1, 0);
        tbl[3]  = mk(1, 4'b1111, 1, 2'd0, 0, 1, 0);
        tbl[4]  = mk(1, 4'b1111, 0, 2'd0, 0, 0, 0);
        tbl[5]  = mk(1, 4'b1111, 0, 2'd1, 1, 1, 0);
        tbl[6]  = mk(1, 4'b1111, 1, 2'd1, 0, 1, 0);
        tbl[7]  = mk(1, 4'b1111, 0, 2'd1, 0, 0, 0);
        tbl[8]  = mk(1, 4'b1111, 0, 2'd2, 1, 1, 0);
        tbl[9]  = mk(1, 4'b1111, 1, 2'd2, 0, 1, 0);
        tbl[10] = mk(1, 4'b1111, 0, 2'd2, 0, 0, 0);
        tbl[11] = mk(1, 4'b1111, 0, 2'd3, 1, 1, 0);
        tbl[12] = mk(1, 4'b1111, 1, 2'd3, 0, 1, 0);
        tbl[13] = mk(1, 4'b1111, 0, 2'd3, 0, 0, 0);
        tbl[14] = mk(1, 4'b1111, 0, 2'd0, 1, 1, 0);
        tbl[15] = mk(1, 4'b1111, 1, 2'd0, 0, 1, 0);
        tbl[16] = mk(1, 4'b1001, 1, 2'd0, 0, 0, 0);
        tbl[17] = mk(1, 4'b1001, 0, 2'd3, 1, 1, 0);
        tbl[18] = mk(1, 4'b1001, 1, 2'd3, 0, 1, 0);
        tbl[19] = mk(1, 4'b1001, 0, 2'd3, 0, 0, 0);
        tbl[20] = mk(1, 4'b1001, 0, 2'd0, 1, 1, 0);
        tbl[21] = mk(1, 4'b0000, 0, 2'd0, 0, 1, 0);
        tbl[22] = mk(1, 4'b0000, 0, 2'd0, 0, 0, 0);
        tbl[23] = mk(1, 4'b0000, 0, 2'd0, 0, 0, 0);
        tbl[24] = mk(1, 4'b0000, 1, 2'd0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            reset_n       = tbl[i].rst_n;
            req           = tbl[i].req;
            release_grant = tbl[i].rel;
            step();
            check($sformatf("vec%0d", i), tbl[i].a, tbl[i].e, tbl[i].b, tbl[i].t);
        end

        // Hold timeout: ptr=1, only requester 2 asks and never releases.
        req = 4'b0100;
        release_grant = 1'b0;
        step();
        check("to_grant", 2'd2, 1, 1, 0);
        for (int k = 1; k < 15; k++) begin
            step();
            check($sformatf("to_hold%0d", k), 2'd2, 1, 1, 0);
        end
        step();
        check("to_pulse", 2'd2, 0, 1, 1);
        step();
        check("to_idle", 2'd2, 0, 0, 0);
        step();
        check("to_regrant", 2'd2, 1, 1, 0);
        release_grant = 1'b1;
        req = 4'b0000;
        step();
        check("to_rel", 2'd2, 0, 1, 0);
        release_grant = 1'b0;
        step();
        check("to_rel_idle", 2'd2, 0, 0, 0);

        // Request drop: ptr=3, requester 1 is picked after wrapping, drops after 4 cycles.
        req = 4'b0010;
        step();
        check("drop_grant", 2'd1, 1, 1, 0);
        for (int k = 1; k < 4; k++) begin
            step();
            check($sformatf("drop_hold%0d", k), 2'd1, 1, 1, 0);
        end
        req = 4'b0000;
        step();
        check("drop_end", 2'd1, 0, 1, 0);
        req = 4'b1111;
        step();
        check("drop_gap", 2'd1, 0, 0, 0);
        step();
        check("drop_ptr2", 2'd2, 1, 1, 0);

        // Asynchronous reset mid-grant.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_now", 2'd0, 0, 0, 0);
        step();
        check("arst_hold", 2'd0, 0, 0, 0);
        reset_n = 1'b1;
        step();
        check("arst_ptr0", 2'd0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
